// File: rtl/demux_pkg.sv
// Shared widths, channel-select type and push payload for the nibble demux.
package demux_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_sel_e;

  typedef struct packed {
    ch_sel_e             ch;
    logic [NIBBLE_W-1:0] data;
  } push_req_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small nibble FIFO with combinational head; refuses push when full, even on a same-cycle pop.
module nibble_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [NIBBLE_W-1:0] wdata,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [NIBBLE_W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [NIBBLE_W-1:0] mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/demux1t2_4_buf.sv
// 1-to-2 nibble demultiplexer with a FIFO per channel and per-channel accept counters.
module demux1t2_4_buf
  import demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s,
  input  logic [NIBBLE_W-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [NIBBLE_W-1:0] d0,
  output logic                d0_valid,
  input  logic                d0_ready,
  output logic [NIBBLE_W-1:0] d1,
  output logic                d1_valid,
  input  logic                d1_ready,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1
);

  push_req_t req;
  logic      full0, full1;
  logic      empty0, empty1;
  logic      accept;
  logic      push0, push1;
  logic      pop0, pop1;

  // Routing and ready depend only on s and the selected FIFO's full flag.
  assign req       = '{ch: ch_sel_e'(s), data: din};
  assign din_ready = (req.ch == CH1) ? ~full1 : ~full0;
  assign accept    = din_valid & din_ready;
  assign push0     = accept & (req.ch == CH0);
  assign push1     = accept & (req.ch == CH1);

  assign d0_valid  = ~empty0;
  assign d1_valid  = ~empty1;
  assign pop0      = d0_valid & d0_ready;
  assign pop1      = d1_valid & d1_ready;

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (req.data),
    .pop   (pop0),
    .full  (full0),
    .empty (empty0),
    .head  (d0)
  );

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (req.data),
    .pop   (pop1),
    .full  (full1),
    .empty (empty1),
    .head  (d1)
  );

  // Wrapping per-channel accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + CNT_W'(1);
      if (push1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux1t2_4_buf.sv
// Scoreboard bench for demux1t2_4_buf: queue model per channel plus directed scenario checks.
module tb_demux1t2_4_buf;

  localparam int unsigned DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] d0, d1;
  logic       d0_valid, d1_valid;
  logic       d0_ready, d1_ready;
  logic [7:0] cnt0, cnt1;

  int vectors;
  int miscompares;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [7:0] mc0, mc1;

  demux1t2_4_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .d0        (d0),
    .d0_valid  (d0_valid),
    .d0_ready  (d0_ready),
    .d1        (d1),
    .d1_valid  (d1_valid),
    .d1_ready  (d1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor/model: checks the DUT against the queues mid-cycle, then applies the coming edge.
  initial begin
    logic exp_ready;
    logic pop0, pop1;
    mc0 = '0;
    mc1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        mc0 = '0;
        mc1 = '0;
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_d0_valid", 32'(d0_valid), 32'd0);
        chk("rst_d1_valid", 32'(d1_valid), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
      end else begin
        chk("d0_valid", 32'(d0_valid), 32'(q0.size() != 0));
        chk("d1_valid", 32'(d1_valid), 32'(q1.size() != 0));
        chk("d0", 32'(d0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        chk("d1", 32'(d1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
        chk("cnt0", 32'(cnt0), 32'(mc0));
        chk("cnt1", 32'(cnt1), 32'(mc1));
        exp_ready = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        chk("din_ready", 32'(din_ready), 32'(exp_ready));
        pop0 = (q0.size() != 0) && d0_ready;
        pop1 = (q1.size() != 0) && d1_ready;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (din_valid && exp_ready) begin
          if (s) begin q1.push_back(din); mc1 = mc1 + 8'd1; end
          else   begin q0.push_back(din); mc0 = mc0 + 8'd1; end
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    s           = 1'b0;
    din         = 4'h0;
    din_valid   = 1'b0;
    d0_ready    = 1'b0;
    d1_ready    = 1'b0;
    #2;
    chk("por_din_ready", 32'(din_ready), 32'd1);
    chk("por_d0", 32'(d0), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // First push lands on channel 0 and is visible right after the edge.
    s = 1'b0; din = 4'hA; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("t36_d0", 32'(d0), 32'hA);
    chk("t36_d0_valid", 32'(d0_valid), 32'd1);
    chk("t36_d1_valid", 32'(d1_valid), 32'd0);
    chk("t36_cnt0", 32'(cnt0), 32'd1);

    // Fill channel 0; third push refused, channel 1 still accepts.
    do_reset();
    s = 1'b0; din = 4'h3; din_valid = 1'b1;
    #1 chk("t37_rdy3", 32'(din_ready), 32'd1);
    step();
    din = 4'h5;
    #1 chk("t37_rdy5", 32'(din_ready), 32'd1);
    step();
    din = 4'h7;
    #1 chk("t37_rdy7", 32'(din_ready), 32'd0);
    s = 1'b1; din = 4'h9;
    #1 chk("t37_rdy_ch1", 32'(din_ready), 32'd1);
    step();
    chk("t37_d1", 32'(d1), 32'h9);
    chk("t37_d0", 32'(d0), 32'h3);
    chk("t37_cnt0", 32'(cnt0), 32'd2);

    // Full channel 0 with a pop: push refused this cycle, accepted next.
    s = 1'b0; din = 4'h7; d0_ready = 1'b1; d1_ready = 1'b1;
    #1 chk("t38_rdy_full", 32'(din_ready), 32'd0);
    step();
    chk("t38_d0_after_pop", 32'(d0), 32'h5);
    chk("t38_rdy_next", 32'(din_ready), 32'd1);
    step();
    din_valid = 1'b0;
    chk("t38_d0_new", 32'(d0), 32'h7);
    chk("t38_cnt0", 32'(cnt0), 32'd3);
    step();
    step();

    // Interleaved routing with both sinks ready.
    do_reset();
    d0_ready = 1'b1; d1_ready = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s   = 1'(i % 2);
      din = 4'(i + 1);
      step();
      if (i == 0) chk("t39_d0_first", 32'(d0), 32'h1);
      if (i == 1) chk("t39_d1_first", 32'(d1), 32'h2);
    end
    din_valid = 1'b0;
    chk("t39_cnt0", 32'(cnt0), 32'd2);
    chk("t39_cnt1", 32'(cnt1), 32'd2);
    step();

    // 256 pushes to channel 1 wrap its counter.
    do_reset();
    s = 1'b1; din_valid = 1'b1; d1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      din = 4'(i);
      step();
      if (i == 254) chk("t40_cnt1_ff", 32'(cnt1), 32'hFF);
    end
    din_valid = 1'b0;
    chk("t40_cnt1_wrap", 32'(cnt1), 32'd0);
    chk("t40_cnt0", 32'(cnt0), 32'd0);
    step();

    // Mid-cycle reset with data in both FIFOs.
    do_reset();
    d0_ready = 1'b0; d1_ready = 1'b0; din_valid = 1'b1;
    s = 1'b0; din = 4'h6; step();
    s = 1'b1; din = 4'hC; step();
    din_valid = 1'b0;
    chk("t41_pre_d0_valid", 32'(d0_valid), 32'd1);
    chk("t41_pre_d1", 32'(d1), 32'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("t41_d0_valid", 32'(d0_valid), 32'd0);
    chk("t41_d1_valid", 32'(d1_valid), 32'd0);
    chk("t41_d0", 32'(d0), 32'd0);
    chk("t41_d1", 32'(d1), 32'd0);
    chk("t41_cnt0", 32'(cnt0), 32'd0);
    chk("t41_cnt1", 32'(cnt1), 32'd0);
    chk("t41_rdy_s1", 32'(din_ready), 32'd1);
    s = 1'b0;
    #1 chk("t41_rdy_s0", 32'(din_ready), 32'd1);
    step();
    rst_n = 1'b1;
    // First edge after release accepts a transfer.
    s = 1'b0; din = 4'h2; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("t32_d0", 32'(d0), 32'h2);
    chk("t32_cnt0", 32'(cnt0), 32'd1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
